ct_rtu_ptr_decode_8: RTL and testbench

8-entry circular retire/commit pointer for RTU queues. Holds the pointer as a registered one-hot vector plus a binary copy and a wrap bit, and performs the binary-to-one-hot conversion (3-bit to 8-bit expand) on the load path. Consumers are queue entry select logic, which needs one-hot current and look-ahead pointers, and full/empty compare logic, which needs binary and wrap. Sits beside 8-entry RTU queues and is the decode-side counterpart of the one-hot-to-binary encode used on their read side.

---
 rtl/ct_rtu_ptr_decode_8_pkg.sv | 20 ++
 rtl/ct_rtu_ptr_decode_8_decode.sv | 19 +
 rtl/ct_rtu_ptr_decode_8.sv | 96 +++++++++
 tb/tb_ct_rtu_ptr_decode_8.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ct_rtu_ptr_decode_8_pkg.sv
// Shared constants and helpers for 8-entry RTU circular pointers.
// Provides pointer width/depth, reset one-hot value and rotate helper.
package ct_rtu_ptr_decode_8_pkg;

    localparam int RTU_PTR8_W     = 3;
    localparam int RTU_PTR8_DEPTH = 8;

    localparam logic [RTU_PTR8_DEPTH-1:0] RTU_PTR8_RST_ONEHOT = 8'b0000_0001;

    // Rotate an 8-bit one-hot left by 0..3 positions.
    function automatic logic [RTU_PTR8_DEPTH-1:0] rtu_rotl8(
        input logic [RTU_PTR8_DEPTH-1:0] v,
        input logic [1:0]                n
    );
        logic [2*RTU_PTR8_DEPTH-1:0] t;
        t = {v, v} << n;
        return t[2*RTU_PTR8_DEPTH-1:RTU_PTR8_DEPTH];
    endfunction

endpackage

// File: rtl/ct_rtu_ptr_decode_8_decode.sv
// Combinational 3-bit binary to 8-bit one-hot decoder.
// Ports: x_num (binary in), x_onehot (bit i set iff x_num == i).
module ct_rtu_decode_8
    import ct_rtu_ptr_decode_8_pkg::*;
(
    input  logic [RTU_PTR8_W-1:0]     x_num,
    output logic [RTU_PTR8_DEPTH-1:0] x_onehot
);

    always_comb begin
        x_onehot = '0;
        for (int i = 0; i < RTU_PTR8_DEPTH; i++) begin
            if (x_num == RTU_PTR8_W'(i)) begin
                x_onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ct_rtu_ptr_decode_8.sv
// 8-entry circular retire/commit pointer: one-hot + binary + wrap state.
// Inputs: clk, sync reset, load (num/wrap), inc (0..3).
// Outputs: one-hot current and +1/+2/+3 look-ahead, binary, wrap,
// update pulse and one-hot integrity error flag.
module ct_rtu_ptr_decode_8
    import ct_rtu_ptr_decode_8_pkg::*;
#(
    parameter logic [2:0] RST_NUM  = 3'd0,
    parameter logic       RST_WRAP = 1'b0
) (
    input  logic                      forever_cpuclk,
    input  logic                      cpurst,
    input  logic                      x_load_en,
    input  logic [RTU_PTR8_W-1:0]     x_load_num,
    input  logic                      x_load_wrap,
    input  logic                      x_inc_en,
    input  logic [1:0]                x_inc_num,
    output logic [RTU_PTR8_DEPTH-1:0] x_ptr_expand,
    output logic [RTU_PTR8_DEPTH-1:0] x_ptr_expand_plus1,
    output logic [RTU_PTR8_DEPTH-1:0] x_ptr_expand_plus2,
    output logic [RTU_PTR8_DEPTH-1:0] x_ptr_expand_plus3,
    output logic [RTU_PTR8_W-1:0]     x_ptr_num,
    output logic                      x_ptr_wrap,
    output logic                      x_ptr_updt,
    output logic                      x_ptr_err
);

    logic [RTU_PTR8_DEPTH-1:0] expand_q, expand_d;
    logic [RTU_PTR8_W-1:0]     num_q, num_d;
    logic                      wrap_q, wrap_d;
    logic                      updt_q, updt_d;
    logic                      err_q, err_d;

    logic [RTU_PTR8_DEPTH-1:0] load_onehot;
    logic [RTU_PTR8_DEPTH-1:0] rst_onehot;
    logic [RTU_PTR8_W:0]       inc_sum;

    ct_rtu_decode_8 u_load_dec (
        .x_num    (x_load_num),
        .x_onehot (load_onehot)
    );

    ct_rtu_decode_8 u_rst_dec (
        .x_num    (RST_NUM),
        .x_onehot (rst_onehot)
    );

    // Carry out of the 4-bit sum marks crossing entry 7 -> 0.
    assign inc_sum = {1'b0, num_q} + {2'b00, x_inc_num};

    always_comb begin
        expand_d = expand_q;
        num_d    = num_q;
        wrap_d   = wrap_q;
        updt_d   = 1'b0;
        if (x_load_en) begin
            expand_d = load_onehot;
            num_d    = x_load_num;
            wrap_d   = x_load_wrap;
            updt_d   = 1'b1;
        end else if (x_inc_en && (x_inc_num != 2'd0)) begin
            expand_d = rtu_rotl8(expand_q, x_inc_num);
            num_d    = inc_sum[RTU_PTR8_W-1:0];
            wrap_d   = wrap_q ^ inc_sum[RTU_PTR8_W];
            updt_d   = 1'b1;
        end
        // Integrity check on what is about to be registered.
        err_d = !$onehot(expand_d);
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            expand_q <= rst_onehot;
            num_q    <= RST_NUM;
            wrap_q   <= RST_WRAP;
            updt_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            expand_q <= expand_d;
            num_q    <= num_d;
            wrap_q   <= wrap_d;
            updt_q   <= updt_d;
            err_q    <= err_d;
        end
    end

    assign x_ptr_expand       = expand_q;
    assign x_ptr_expand_plus1 = rtu_rotl8(expand_q, 2'd1);
    assign x_ptr_expand_plus2 = rtu_rotl8(expand_q, 2'd2);
    assign x_ptr_expand_plus3 = rtu_rotl8(expand_q, 2'd3);
    assign x_ptr_num          = num_q;
    assign x_ptr_wrap         = wrap_q;
    assign x_ptr_updt         = updt_q;
    assign x_ptr_err          = err_q;

endmodule

// File: tb/tb_ct_rtu_ptr_decode_8.sv
// Self-checking bench for ct_rtu_ptr_decode_8.
// Directed scenarios plus randomized traffic against an integer model.
module tb_ct_rtu_ptr_decode_8;

    logic       clk;
    logic       cpurst;
    logic       load_en;
    logic [2:0] load_num;
    logic       load_wrap;
    logic       inc_en;
    logic [1:0] inc_num;
    logic [7:0] expand, plus1, plus2, plus3;
    logic [2:0] num;
    logic       wrap, updt, err;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: pointer as plain integer position 0..7.
    int m_num  = 0;
    int m_wrap = 0;
    int m_updt = 0;

    ct_rtu_ptr_decode_8 dut (
        .forever_cpuclk     (clk),
        .cpurst             (cpurst),
        .x_load_en          (load_en),
        .x_load_num         (load_num),
        .x_load_wrap        (load_wrap),
        .x_inc_en           (inc_en),
        .x_inc_num          (inc_num),
        .x_ptr_expand       (expand),
        .x_ptr_expand_plus1 (plus1),
        .x_ptr_expand_plus2 (plus2),
        .x_ptr_expand_plus3 (plus3),
        .x_ptr_num          (num),
        .x_ptr_wrap         (wrap),
        .x_ptr_updt         (updt),
        .x_ptr_err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] oh(input int pos);
        logic [7:0] r;
        r = 8'd0;
        r[pos % 8] = 1'b1;
        return r;
    endfunction

    // Drive one cycle (called just after a negedge), update model at the
    // edge, return at the following negedge for sampling.
    task automatic step(input logic r, input logic le, input int ln,
                        input logic lw, input logic ie, input int in_n);
        cpurst    = r;
        load_en   = le;
        load_num  = 3'(ln);
        load_wrap = lw;
        inc_en    = ie;
        inc_num   = 2'(in_n);
        @(posedge clk);
        if (r) begin
            m_num = 0; m_wrap = 0; m_updt = 0;
        end else if (le) begin
            m_num = ln; m_wrap = lw; m_updt = 1;
        end else if (ie && in_n != 0) begin
            if (m_num + in_n >= 8) m_wrap = 1 - m_wrap;
            m_num  = (m_num + in_n) % 8;
            m_updt = 1;
        end else begin
            m_updt = 0;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        cpurst = 1; load_en = 1; load_num = 3'd5; load_wrap = 1;
        inc_en = 1; inc_num = 2'd2;
        @(negedge clk);
        step(1, 1, 5, 1, 1, 2);
        step(1, 1, 5, 1, 1, 2);
        cpurst = 0; load_en = 0; inc_en = 0;
        tests_run++;
        if (expand !== 8'h01 || num !== 3'd0 || wrap !== 1'b0 ||
            updt !== 1'b0 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset: exp=%h num=%0d wrap=%b updt=%b err=%b, want 01/0/0/0/0",
                     expand, num, wrap, updt, err);
        end
        tests_run++;
        if (plus1 !== 8'h02 || plus2 !== 8'h04 || plus3 !== 8'h08) begin
            tests_failed++;
            $display("FAIL reset_lookahead: p1=%h p2=%h p3=%h, want 02/04/08",
                     plus1, plus2, plus3);
        end
    endtask

    task automatic test_wrap_inc3();
        step(0, 1, 6, 0, 0, 0);
        step(0, 0, 0, 0, 1, 3);
        tests_run++;
        if (num !== 3'd1 || expand !== 8'h02 || wrap !== 1'b1 || updt !== 1'b1) begin
            tests_failed++;
            $display("FAIL wrap_inc3: num=%0d exp=%h wrap=%b updt=%b, want 1/02/1/1",
                     num, expand, wrap, updt);
        end
        idle();
        tests_run++;
        if (updt !== 1'b0 || num !== 3'd1) begin
            tests_failed++;
            $display("FAIL wrap_idle: updt=%b num=%0d, want 0/1", updt, num);
        end
    endtask

    task automatic test_sweep();
        int bad;
        bad = 0;
        step(1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 16; i++) begin
            step(0, 0, 0, 0, 1, 1);
            if (num !== 3'(i % 8) || wrap !== 1'((i / 8) % 2) ||
                expand !== oh(i) || err !== 1'b0 || updt !== 1'b1) begin
                bad++;
                $display("FAIL sweep[%0d]: num=%0d wrap=%b exp=%h err=%b updt=%b",
                         i, num, wrap, expand, err, updt);
            end
        end
        tests_run++;
        if (bad != 0) tests_failed++;
    endtask

    task automatic test_load_vs_inc();
        step(0, 1, 4, 1, 1, 2);
        tests_run++;
        if (num !== 3'd4 || expand !== 8'h10 || wrap !== 1'b1 || updt !== 1'b1) begin
            tests_failed++;
            $display("FAIL load_vs_inc: num=%0d exp=%h wrap=%b updt=%b, want 4/10/1/1",
                     num, expand, wrap, updt);
        end
        tests_run++;
        if (plus3 !== 8'h80 || plus2 !== 8'h40) begin
            tests_failed++;
            $display("FAIL load_lookahead: p2=%h p3=%h, want 40/80", plus2, plus3);
        end
    endtask

    task automatic test_inc_zero();
        step(0, 1, 3, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        tests_run++;
        if (num !== 3'd3 || expand !== 8'h08 || updt !== 1'b0 || wrap !== 1'b0) begin
            tests_failed++;
            $display("FAIL inc_zero: num=%0d exp=%h updt=%b wrap=%b, want 3/08/0/0",
                     num, expand, updt, wrap);
        end
        step(0, 1, 3, 0, 0, 0);
        tests_run++;
        if (num !== 3'd3 || updt !== 1'b1) begin
            tests_failed++;
            $display("FAIL reload_same: num=%0d updt=%b, want 3/1", num, updt);
        end
    endtask

    task automatic test_err_backdoor();
        force dut.expand_q = 8'h03;
        idle();
        tests_run++;
        if (err !== 1'b1) begin
            tests_failed++;
            $display("FAIL err_set: err=%b, want 1", err);
        end
        release dut.expand_q;
        step(0, 1, 2, 0, 0, 0);
        tests_run++;
        if (err !== 1'b0 || expand !== 8'h04 || num !== 3'd2) begin
            tests_failed++;
            $display("FAIL err_clear: err=%b exp=%h num=%0d, want 0/04/2",
                     err, expand, num);
        end
    endtask

    task automatic test_random();
        int bad;
        logic r, le, lw, ie;
        int ln, in_n;
        bad = 0;
        for (int c = 0; c < 400; c++) begin
            r    = ($urandom_range(0, 31) == 0);
            le   = ($urandom_range(0, 3) == 0);
            ln   = $urandom_range(0, 7);
            lw   = 1'($urandom_range(0, 1));
            ie   = ($urandom_range(0, 1) == 1);
            in_n = $urandom_range(0, 3);
            step(r, le, ln, lw, ie, in_n);
            if (num !== 3'(m_num) || wrap !== 1'(m_wrap) ||
                updt !== 1'(m_updt) || err !== 1'b0 ||
                expand !== oh(m_num) || plus1 !== oh(m_num + 1) ||
                plus2 !== oh(m_num + 2) || plus3 !== oh(m_num + 3)) begin
                bad++;
                if (bad < 10)
                    $display("FAIL random[%0d]: num=%0d/%0d wrap=%b/%0d updt=%b/%0d exp=%h err=%b",
                             c, num, m_num, wrap, m_wrap, updt, m_updt, expand, err);
            end
        end
        tests_run++;
        if (bad != 0) tests_failed++;
    endtask

    initial begin
        test_reset();
        test_wrap_inc3();
        test_sweep();
        test_load_vs_inc();
        test_inc_zero();
        test_err_backdoor();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
